e3_accum: RTL and testbench

- Sequential stage directly downstream of the excess-3 digit multiplier: consumes its 8-bit two-digit excess-3 product and adds it into a running multi-digit excess-3 sum.
- Addition is digit-serial, one digit per clock, under a valid/ready handshake.
- Provides a result-valid pulse, a sticky overflow flag and a sticky invalid-code error flag, for dot-product style accumulation of digit products.

---
 rtl/e3_accum.sv | 146 ++++++++++++++
 tb/tb_e3_accum.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/e3_accum.sv
// ---------------------------------------------------------------------------
// e3_accum
//   Running multi-digit excess-3 accumulator. It sits downstream of the
//   excess-3 digit multiplier and adds each two-digit product into the sum.
//   The addition is digit-serial, one digit per clock, so an operand takes
//   DIGITS cycles to absorb. A new operand can be accepted in the cycle after
//   completion.
//
// Parameters
//   DIGITS     number of excess-3 digits in the accumulator (2..8)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   clr        synchronous clear, same effect as rst
//   in_valid   in_data holds an operand
//   in_ready   operand can be accepted this cycle
//   in_data    operand in excess-3: [7:4] tens digit, [3:0] units digit
//   sum        accumulated value in excess-3, digit 0 at [3:0]
//   out_valid  one-cycle pulse after sum is updated by a completed addition
//   ovf        sticky: a completed addition carried out of the top digit
//   err        sticky: an accepted operand held an invalid excess-3 code
// ---------------------------------------------------------------------------
module e3_accum #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  out_valid,
    output logic                  ovf,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state;
    logic [W-1:0]     work;      // working copy of sum, rotated one digit per cycle
    logic [W-1:0]     opnd;      // operand, shifted alongside work
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [W-1:0]     op_ext;
    logic [W-1:0]     work_next;
    logic [4:0]       step;
    logic             accept;
    logic             bad_op;

    // True when a 4-bit code is outside the excess-3 digit range 3..12.
    function automatic logic bad_code(input logic [3:0] d);
        return (d < 4'd3) || (d > 4'd12);
    endfunction

    // One excess-3 digit addition; returns {carry_out, result_digit}.
    function automatic logic [4:0] digit_add(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       c);
        logic [4:0] t;
        t = ({1'b0, a} - 5'd3) + ({1'b0, b} - 5'd3) + {4'b0000, c};
        if (t >= 5'd10)
            return {1'b1, 4'(t - 5'd10) + 4'd3};
        else
            return {1'b0, t[3:0] + 4'd3};
    endfunction

    // rst/clr gate in_ready directly so no operand slips in during a clear.
    assign in_ready = (state == IDLE) && !rst && !clr;
    assign accept   = in_valid && in_ready;
    assign bad_op   = bad_code(in_data[7:4]) || bad_code(in_data[3:0]);

    // Operand zero-extended with excess-3 zeros in the upper digits.
    always_comb begin
        op_ext = '0;
        for (int k = 0; k < DIGITS; k++)
            op_ext[4*k +: 4] = 4'h3;
        op_ext[7:0] = in_data;
    end

    // The low digit is always the one being processed; the result enters at
    // the top so that after DIGITS steps the word is back in digit order.
    always_comb begin
        step      = digit_add(work[3:0], opnd[3:0], carry);
        work_next = {step[3:0], work[W-1:4]};
    end

    // Control and visible state.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= IDLE;
            sum       <= {DIGITS{4'h3}};
            ovf       <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad_op) begin
                            err <= 1'b1;
                        end else begin
                            carry <= 1'b0;
                            idx   <= '0;
                            state <= ADD;
                        end
                    end
                end
                ADD: begin
                    carry <= step[4];
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST) begin
                        sum       <= work_next;
                        ovf       <= ovf | step[4];
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Working registers: loaded at acceptance, shifted while adding.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (accept && !bad_op) begin
                work <= sum;
                opnd <= op_ext;
            end
        end else begin
            work <= work_next;
            opnd <= {4'h3, opnd[W-1:4]};
        end
    end

endmodule

// File: tb/tb_e3_accum.sv
module tb_e3_accum;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DIGITS = 4
    logic        rst_a, clr_a, in_valid_a, in_ready_a, out_valid_a, ovf_a, err_a;
    logic [7:0]  in_data_a;
    logic [15:0] sum_a;

    // Instance B: DIGITS = 2
    logic        rst_b, clr_b, in_valid_b, in_ready_b, out_valid_b, ovf_b, err_b;
    logic [7:0]  in_data_b;
    logic [7:0]  sum_b;

    int passed = 0;
    int total  = 0;

    e3_accum #(.DIGITS(4)) dut_a (
        .clk(clk), .rst(rst_a), .clr(clr_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_data(in_data_a), .sum(sum_a),
        .out_valid(out_valid_a), .ovf(ovf_a), .err(err_a)
    );

    e3_accum #(.DIGITS(2)) dut_b (
        .clk(clk), .rst(rst_b), .clr(clr_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_data(in_data_b), .sum(sum_b),
        .out_valid(out_valid_b), .ovf(ovf_b), .err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; clr_a = 1'b0; in_valid_a = 1'b0; in_data_a = 8'h33;
        rst_b = 1'b1; clr_b = 1'b0; in_valid_b = 1'b0; in_data_b = 8'h33;
        #1;
        chk("a_ready_in_reset", in_ready_a, 0);
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk("a_rst_sum", sum_a, 32'h3333);
        chk("a_rst_ovf", ovf_a, 0);
        chk("a_rst_err", err_a, 0);
        chk("a_rst_ovalid", out_valid_a, 0);
        chk("a_rst_ready", in_ready_a, 1);
        chk("b_rst_sum", sum_b, 32'h33);

        // Single add 81
        in_valid_a = 1'b1; in_data_a = 8'hB4;
        tick();                       // edge 0: accept
        in_valid_a = 1'b0;
        chk("a1_ready_e0", in_ready_a, 0);
        tick(); chk("a1_ready_e1", in_ready_a, 0);
        tick(); chk("a1_sum_e2_nopartial", sum_a, 32'h3333);
        tick(); chk("a1_ovalid_e3", out_valid_a, 0);
        tick();                       // edge 4: complete
        chk("a1_sum", sum_a, 32'h33B4);
        chk("a1_ovalid", out_valid_a, 1);
        chk("a1_ready_after", in_ready_a, 1);

        // Second 81 -> 162
        in_valid_a = 1'b1; in_data_a = 8'hB4;
        tick();
        in_valid_a = 1'b0;
        chk("a1_ovalid_drop", out_valid_a, 0);
        repeat (4) tick();
        chk("a2_sum", sum_a, 32'h3495);
        chk("a2_ovf", ovf_a, 0);
        chk("a2_ovalid", out_valid_a, 1);

        // 99 accepted in the same cycle as out_valid -> 261
        in_valid_a = 1'b1; in_data_a = 8'hCC;
        chk("a3_ready_coincide", in_ready_a, 1);
        tick();
        in_valid_a = 1'b0;
        repeat (4) tick();
        chk("a3_sum", sum_a, 32'h3594);
        chk("a3_ovalid", out_valid_a, 1);

        // DIGITS=2 overflow
        in_valid_b = 1'b1; in_data_b = 8'hB4;
        tick(); in_valid_b = 1'b0;
        repeat (2) tick();
        chk("b1_sum", sum_b, 32'hB4);
        chk("b1_ovf", ovf_b, 0);
        in_valid_b = 1'b1; in_data_b = 8'hB4;
        tick(); in_valid_b = 1'b0;
        repeat (2) tick();
        chk("b2_sum", sum_b, 32'h95);
        chk("b2_ovf", ovf_b, 1);
        chk("b2_ovalid", out_valid_b, 1);
        in_valid_b = 1'b1; in_data_b = 8'h36;
        tick(); in_valid_b = 1'b0;
        repeat (2) tick();
        chk("b3_sum", sum_b, 32'h98);
        chk("b3_ovf_sticky", ovf_b, 1);

        // Invalid code on A
        in_valid_a = 1'b1; in_data_a = 8'hF3;
        tick(); in_valid_a = 1'b0;
        chk("inv_err", err_a, 1);
        chk("inv_sum", sum_a, 32'h3594);
        chk("inv_ovalid", out_valid_a, 0);
        chk("inv_ready_idle", in_ready_a, 1);
        tick();
        chk("inv_ovalid_next", out_valid_a, 0);
        chk("inv_sum_next", sum_a, 32'h3594);

        // Low invalid digit, err stays sticky
        in_valid_a = 1'b1; in_data_a = 8'h32;
        tick(); in_valid_a = 1'b0;
        chk("inv2_err", err_a, 1);
        chk("inv2_ready", in_ready_a, 1);

        // clr
        clr_a = 1'b1;
        #1;
        chk("clr_ready_low", in_ready_a, 0);
        tick(); clr_a = 1'b0;
        #1;
        chk("clr_err", err_a, 0);
        chk("clr_ovf", ovf_a, 0);
        chk("clr_sum", sum_a, 32'h3333);

        // clr on B clears sticky ovf
        clr_b = 1'b1;
        tick(); clr_b = 1'b0;
        chk("b_clr_ovf", ovf_b, 0);
        chk("b_clr_sum", sum_b, 32'h33);

        // clr mid-ADD with in_valid held high
        in_valid_a = 1'b1; in_data_a = 8'hB4;
        tick();                       // edge 0: accept
        chk("mid_ready_e0", in_ready_a, 0);
        tick();                       // edge 1
        clr_a = 1'b1;
        #1;
        chk("mid_ready_clr", in_ready_a, 0);
        tick();                       // edge 2: clear
        clr_a = 1'b0;
        #1;
        chk("mid_sum", sum_a, 32'h3333);
        chk("mid_ovalid", out_valid_a, 0);
        chk("mid_ready_after", in_ready_a, 1);
        tick();                       // held operand accepted
        in_valid_a = 1'b0;
        chk("mid_ready_busy", in_ready_a, 0);
        repeat (3) tick();
        chk("mid_ovalid_e3", out_valid_a, 0);
        tick();
        chk("mid_sum_final", sum_a, 32'h33B4);
        chk("mid_ovalid_final", out_valid_a, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
